// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: main intersection controller.
// Sequences main-street green/yellow, optional pedestrian walk, side-street
// green (with at most one extension per pass) and side yellow, all timed in
// ticks of an external 1 Hz enable. Interval registers are reprogrammable at
// run time; any reprogram strobe restarts the cycle at MAIN_GREEN.
//
// Ports:
//   clock, reset          single clock, async active-high reset
//   tick                  one-cycle timing enable
//   sensor_sync           side-street vehicle present (level)
//   wr_sync               walk request (level)
//   prog_sync             reprogram strobe
//   time_sel[1:0]         00 base, 01 ext, 10 yellow, 11 none
//   time_value[3:0]       new interval in ticks, 0 = parameter default
//   main_lamp/side_lamp   {red, yellow, green}
//   walk_lamp             pedestrian walk lamp
//   state_dbg             current state encoding
module traffic_light_fsm #(
  parameter logic [3:0] T_BASE_DEF = 4'd6,
  parameter logic [3:0] T_EXT_DEF  = 4'd3,
  parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       sensor_sync,
  input  logic       wr_sync,
  input  logic       prog_sync,
  input  logic [1:0] time_sel,
  input  logic [3:0] time_value,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk_lamp,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] MAIN_GREEN     = 3'd0;
  localparam logic [2:0] MAIN_YELLOW    = 3'd1;
  localparam logic [2:0] WALK           = 3'd2;
  localparam logic [2:0] SIDE_GREEN     = 3'd3;
  localparam logic [2:0] SIDE_GREEN_EXT = 3'd4;
  localparam logic [2:0] SIDE_YELLOW    = 3'd5;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0] state, state_nxt;
  logic [4:0] elapsed;      // 5 bits so MAIN_GREEN can run to 2*T_BASE
  logic       walk_pending;
  logic [3:0] t_base, t_ext, t_yel;

  logic [4:0] dur, el_inc;
  logic [3:0] load_val;
  logic       legal, early, adv;

  assign legal    = (state <= SIDE_YELLOW);
  assign el_inc   = elapsed + 5'd1;
  assign load_val = time_value;

  always_comb begin
    dur = {1'b0, t_base};
    case (state)
      MAIN_GREEN:                dur = {t_base, 1'b0};
      MAIN_YELLOW, SIDE_YELLOW:  dur = {1'b0, t_yel};
      WALK, SIDE_GREEN_EXT:      dur = {1'b0, t_ext};
      default:                   dur = {1'b0, t_base};
    endcase
  end

  // Main green may cut short once the base interval is served and a side
  // vehicle is waiting.
  assign early = (state == MAIN_GREEN) && sensor_sync && (el_inc >= {1'b0, t_base});
  assign adv   = tick && legal && ((el_inc == dur) || early);

  always_comb begin
    state_nxt = MAIN_GREEN;
    case (state)
      MAIN_GREEN:     state_nxt = MAIN_YELLOW;
      MAIN_YELLOW:    state_nxt = walk_pending ? WALK : SIDE_GREEN;
      WALK:           state_nxt = SIDE_GREEN;
      SIDE_GREEN:     state_nxt = sensor_sync ? SIDE_GREEN_EXT : SIDE_YELLOW;
      SIDE_GREEN_EXT: state_nxt = SIDE_YELLOW;
      SIDE_YELLOW:    state_nxt = MAIN_GREEN;
      default:        state_nxt = MAIN_GREEN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= MAIN_GREEN;
      elapsed      <= '0;
      walk_pending <= 1'b0;
      t_base       <= T_BASE_DEF;
      t_ext        <= T_EXT_DEF;
      t_yel        <= T_YEL_DEF;
    end else if (prog_sync) begin
      // Reprogram outranks tick and walk request; holding it parks the FSM.
      state        <= MAIN_GREEN;
      elapsed      <= '0;
      walk_pending <= 1'b0;
      case (time_sel)
        2'b00:   t_base <= (load_val == 4'd0) ? T_BASE_DEF : load_val;
        2'b01:   t_ext  <= (load_val == 4'd0) ? T_EXT_DEF  : load_val;
        2'b10:   t_yel  <= (load_val == 4'd0) ? T_YEL_DEF  : load_val;
        default: ;
      endcase
    end else begin
      if (!legal) begin
        state   <= MAIN_GREEN;
        elapsed <= '0;
      end else if (adv) begin
        state   <= state_nxt;
        elapsed <= '0;
      end else if (tick) begin
        elapsed <= el_inc;
      end
      // A request in the same cycle as WALK entry survives for the next pass.
      if (wr_sync)
        walk_pending <= 1'b1;
      else if (adv && (state_nxt == WALK))
        walk_pending <= 1'b0;
    end
  end

  // Pure decode of the state register; illegal codes show all-red.
  always_comb begin
    main_lamp = LAMP_R;
    side_lamp = LAMP_R;
    walk_lamp = 1'b0;
    case (state)
      MAIN_GREEN:                 main_lamp = LAMP_G;
      MAIN_YELLOW:                main_lamp = LAMP_Y;
      WALK:                       walk_lamp = 1'b1;
      SIDE_GREEN, SIDE_GREEN_EXT: side_lamp = LAMP_G;
      SIDE_YELLOW:                side_lamp = LAMP_Y;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: phase tables (state, lamps, length in
// ticks) plus hand-written reprogram and mid-phase reset sequences.
module tb_traffic_light_fsm;

  localparam logic [2:0] MG = 3'd0, MY = 3'd1, WK = 3'd2, SG = 3'd3, SX = 3'd4, SY = 3'd5;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       sensor_sync = 1'b0;
  logic       wr_sync = 1'b0;
  logic       prog_sync = 1'b0;
  logic [1:0] time_sel = 2'b11;
  logic [3:0] time_value = 4'd0;
  logic [2:0] main_lamp, side_lamp, state_dbg;
  logic       walk_lamp;

  int errors = 0;
  int checks = 0;

  traffic_light_fsm dut (
    .clock(clock), .reset(reset), .tick(tick), .sensor_sync(sensor_sync),
    .wr_sync(wr_sync), .prog_sync(prog_sync), .time_sel(time_sel),
    .time_value(time_value), .main_lamp(main_lamp), .side_lamp(side_lamp),
    .walk_lamp(walk_lamp), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // tick: one cycle in four, changed just after the active edge
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      cnt  = (cnt + 1) % 4;
      tick = (cnt == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rst;     // reset before this phase
    logic       sensor;
    int         wr;      // 0 none, 1 pulse at phase start, 2 pulse on exit edge
    logic [2:0] st;
    int         ticks;
  } phase_t;

  phase_t tbl[$];

  function automatic phase_t ph(bit rst, logic sensor, int wr, logic [2:0] st, int ticks);
    phase_t p;
    p.rst = rst; p.sensor = sensor; p.wr = wr; p.st = st; p.ticks = ticks;
    return p;
  endfunction

  // expected {main, side, walk} for each state
  function automatic logic [6:0] lamps(logic [2:0] st);
    case (st)
      MG:      return {G, R, 1'b0};
      MY:      return {Y, R, 1'b0};
      WK:      return {R, R, 1'b1};
      SG, SX:  return {R, G, 1'b0};
      SY:      return {R, Y, 1'b0};
      default: return {R, R, 1'b0};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; sensor_sync = 1'b0; wr_sync = 1'b0; prog_sync = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_state", {29'd0, state_dbg}, 32'd0);
    chk("reset_lamps", {25'd0, main_lamp, side_lamp, walk_lamp}, {25'd0, G, R, 1'b0});
    reset = 1'b0;
  endtask

  // Called at a negedge just after the phase was entered; returns at the
  // negedge after it has been left.
  task automatic run_phase(input phase_t p, input string nm);
    int n, cyc;
    n = 0; cyc = 0;
    sensor_sync = p.sensor;
    chk({nm, "_state"}, {29'd0, state_dbg}, {29'd0, p.st});
    chk({nm, "_lamps"}, {25'd0, main_lamp, side_lamp, walk_lamp}, {25'd0, lamps(p.st)});
    while (cyc < 400) begin
      if (state_dbg != p.st) break;
      if (p.wr == 1 && cyc == 0) wr_sync = 1'b1;
      else if (p.wr == 2 && tick && n == p.ticks - 1) wr_sync = 1'b1;
      if (tick) n++;
      @(negedge clock);
      cyc++;
      wr_sync = 1'b0;
    end
    if (cyc >= 400) begin
      errors++; checks++;
      $display("FAIL %s_timeout: still in state %0d after %0d cycles, required exit", nm, state_dbg, cyc);
    end else
      chk({nm, "_ticks"}, n, p.ticks);
  endtask

  initial begin
    // A: idle, 22-tick cycle
    tbl.push_back(ph(1, 0, 0, MG, 12)); tbl.push_back(ph(0, 0, 0, MY, 2));
    tbl.push_back(ph(0, 0, 0, SG, 6));  tbl.push_back(ph(0, 0, 0, SY, 2));
    tbl.push_back(ph(0, 0, 0, MG, 12));
    // B: sensor held, early main exit and exactly one extension
    tbl.push_back(ph(1, 1, 0, MG, 6));  tbl.push_back(ph(0, 1, 0, MY, 2));
    tbl.push_back(ph(0, 1, 0, SG, 6));  tbl.push_back(ph(0, 1, 0, SX, 3));
    tbl.push_back(ph(0, 1, 0, SY, 2));  tbl.push_back(ph(0, 1, 0, MG, 6));
    // C: walk request pulse in MAIN_GREEN, served once
    tbl.push_back(ph(1, 0, 1, MG, 12)); tbl.push_back(ph(0, 0, 0, MY, 2));
    tbl.push_back(ph(0, 0, 0, WK, 3));  tbl.push_back(ph(0, 0, 0, SG, 6));
    tbl.push_back(ph(0, 0, 0, SY, 2));  tbl.push_back(ph(0, 0, 0, MG, 12));
    tbl.push_back(ph(0, 0, 0, MY, 2));  tbl.push_back(ph(0, 0, 0, SG, 6));
    // D: request on the WALK entry edge survives for one more WALK
    tbl.push_back(ph(1, 0, 1, MG, 12)); tbl.push_back(ph(0, 0, 2, MY, 2));
    tbl.push_back(ph(0, 0, 0, WK, 3));  tbl.push_back(ph(0, 0, 0, SG, 6));
    tbl.push_back(ph(0, 0, 0, SY, 2));  tbl.push_back(ph(0, 0, 0, MG, 12));
    tbl.push_back(ph(0, 0, 0, MY, 2));  tbl.push_back(ph(0, 0, 0, WK, 3));
    tbl.push_back(ph(0, 0, 0, SG, 6));  tbl.push_back(ph(0, 0, 0, SY, 2));
    tbl.push_back(ph(0, 0, 0, MG, 12)); tbl.push_back(ph(0, 0, 0, MY, 2));
    tbl.push_back(ph(0, 0, 0, SG, 6));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      run_phase(tbl[i], $sformatf("tbl%0d_st%0d", i, tbl[i].st));
    end

    // E: reprogram yellow to 5 during SIDE_GREEN, then back to default
    do_reset();
    run_phase(ph(0, 0, 0, MG, 12), "e_mg0");
    run_phase(ph(0, 0, 0, MY, 2), "e_my0");
    chk("e_in_sg", {29'd0, state_dbg}, {29'd0, SG});
    repeat (3) @(negedge clock);
    prog_sync = 1'b1; time_sel = 2'b10; time_value = 4'd5;
    @(negedge clock);
    prog_sync = 1'b0; time_sel = 2'b11; time_value = 4'd0;
    chk("e_prog_state", {29'd0, state_dbg}, {29'd0, MG});
    run_phase(ph(0, 0, 0, MG, 12), "e_mg1");
    run_phase(ph(0, 0, 0, MY, 5), "e_my5");
    run_phase(ph(0, 0, 0, SG, 6), "e_sg1");
    run_phase(ph(0, 0, 0, SY, 5), "e_sy5");
    repeat (5) @(negedge clock);
    prog_sync = 1'b1; time_sel = 2'b10; time_value = 4'd0;
    @(negedge clock);
    prog_sync = 1'b0; time_sel = 2'b11;
    chk("e_prog0_state", {29'd0, state_dbg}, {29'd0, MG});
    run_phase(ph(0, 0, 0, MG, 12), "e_mg2");
    run_phase(ph(0, 0, 0, MY, 2), "e_my2");
    run_phase(ph(0, 0, 0, SG, 6), "e_sg2");
    run_phase(ph(0, 0, 0, SY, 2), "e_sy2");

    // G: held reprogram parks MAIN_GREEN and beats a same-cycle walk request
    prog_sync = 1'b1; time_sel = 2'b11; wr_sync = 1'b1;
    @(negedge clock);
    wr_sync = 1'b0;
    repeat (12) @(negedge clock);
    chk("g_hold_state", {29'd0, state_dbg}, {29'd0, MG});
    prog_sync = 1'b0;
    run_phase(ph(0, 0, 0, MG, 12), "g_mg");
    run_phase(ph(0, 0, 0, MY, 2), "g_my");
    run_phase(ph(0, 0, 0, SG, 6), "g_sg_nowalk");

    // F: reset during WALK (with a fresh request pending) clears everything
    do_reset();
    run_phase(ph(0, 0, 1, MG, 12), "f_mg0");
    run_phase(ph(0, 0, 0, MY, 2), "f_my0");
    chk("f_walk_lamp", {31'd0, walk_lamp}, 32'd1);
    @(negedge clock);
    wr_sync = 1'b1;
    @(negedge clock);
    wr_sync = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("f_async_walk", {31'd0, walk_lamp}, 32'd0);
    chk("f_async_main", {29'd0, main_lamp}, {29'd0, G});
    chk("f_async_state", {29'd0, state_dbg}, {29'd0, MG});
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_phase(ph(0, 0, 0, MG, 12), "f_mg1");
    run_phase(ph(0, 0, 0, MY, 2), "f_my1");
    run_phase(ph(0, 0, 0, SG, 6), "f_sg_nowalk");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
